// File: rtl/ifetch_pq.sv
// Instruction fetch unit with a DEPTH-entry prefetch queue and 1-cycle imem.
// Ports: clk, reset, redirect/redirect_pc, imem_en/imem_addr/imem_rdata,
//   out_valid/out_ready/out_pc/out_instr (+ out_err with IFETCH_ALIGN_CHK_EN).
module ifetch_pq #(
  parameter int XLEN = 32,
  parameter int DEPTH = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_en,
  output logic [XLEN-3:0] imem_addr,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_instr
`ifdef IFETCH_ALIGN_CHK_EN
  ,
  output logic            out_err
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 2;

  logic [XLEN-1:0] pc_mem_q [DEPTH];
  logic [XLEN-1:0] ins_mem_q [DEPTH];
  logic [AW-1:0]   rd_ptr_q;
  logic [AW-1:0]   wr_ptr_q;
  logic [AW:0]     count_q;
  logic [AW:0]     count_d;
  logic [XLEN-1:0] fetch_pc_q;
  logic [XLEN-1:0] fetch_pc_d;
  logic            infl_q;
  logic            infl_d;
  logic [XLEN-1:0] infl_pc_q;
  logic [XLEN-1:0] infl_pc_d;

  logic            pop;
  logic            push;
  logic            issue_ok;
  logic            redir_rd;
  logic            misalign;
  logic            halt_q;
  logic            infl_err_q;
  logic [XLEN-1:0] rpc;
  logic [XLEN-1:0] push_ins;
  logic [CW-1:0]   occ;

`ifdef IFETCH_ALIGN_CHK_EN
  logic            err_mem_q [DEPTH];

  // Misaligned target: no read, one error entry, fetch halts until redirect.
  assign misalign = redirect_pc[1:0] != 2'b00;
  assign rpc      = redirect_pc;
`else
  logic            unused_lo;

  assign unused_lo = ^redirect_pc[1:0];
  assign misalign  = 1'b0;
  assign rpc       = {redirect_pc[XLEN-1:2], 2'b00};
`endif

  assign pop      = out_valid && out_ready && !redirect;
  assign push     = infl_q && !redirect;
  assign occ      = CW'(count_q) + CW'(infl_q);
  // Credit check counts the in-flight slot so a push never hits a full FIFO.
  assign issue_ok = !redirect && !halt_q
                    && (occ < CW'(DEPTH) + CW'(pop));
  assign redir_rd = redirect && !misalign;
  assign push_ins = infl_err_q ? '0 : imem_rdata;

  assign imem_en   = !reset && (redir_rd || issue_ok);
  assign imem_addr = redirect ? redirect_pc[XLEN-1:2]
                              : fetch_pc_q[XLEN-1:2];

  assign out_valid = count_q != '0;
  assign out_pc    = out_valid ? pc_mem_q[rd_ptr_q] : '0;
  assign out_instr = out_valid ? ins_mem_q[rd_ptr_q] : '0;
`ifdef IFETCH_ALIGN_CHK_EN
  assign out_err   = out_valid ? err_mem_q[rd_ptr_q] : 1'b0;
`endif

  always_comb begin
    count_d    = count_q;
    fetch_pc_d = fetch_pc_q;
    infl_d     = 1'b0;
    infl_pc_d  = fetch_pc_q;
    if (redirect) begin
      count_d    = '0;
      fetch_pc_d = rpc + XLEN'(4);
      // A misaligned redirect reuses the in-flight slot for its error entry.
      infl_d     = 1'b1;
      infl_pc_d  = rpc;
    end else begin
      count_d = count_q + (AW+1)'(push) - (AW+1)'(pop);
      infl_d  = issue_ok;
      if (issue_ok) begin
        fetch_pc_d = fetch_pc_q + XLEN'(4);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      fetch_pc_q <= RESET_PC;
      infl_q     <= 1'b0;
      infl_pc_q  <= '0;
      infl_err_q <= 1'b0;
      halt_q     <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem_q[i]  <= '0;
        ins_mem_q[i] <= '0;
`ifdef IFETCH_ALIGN_CHK_EN
        err_mem_q[i] <= 1'b0;
`endif
      end
    end else begin
      count_q    <= count_d;
      fetch_pc_q <= fetch_pc_d;
      infl_q     <= infl_d;
      infl_pc_q  <= infl_pc_d;
      if (redirect) begin
        rd_ptr_q   <= '0;
        wr_ptr_q   <= '0;
        infl_err_q <= misalign;
        halt_q     <= misalign;
      end else begin
        infl_err_q <= 1'b0;
        if (pop) begin
          rd_ptr_q <= rd_ptr_q + 1'b1;
        end
        if (push) begin
          wr_ptr_q            <= wr_ptr_q + 1'b1;
          pc_mem_q[wr_ptr_q]  <= infl_pc_q;
          ins_mem_q[wr_ptr_q] <= push_ins;
`ifdef IFETCH_ALIGN_CHK_EN
          err_mem_q[wr_ptr_q] <= infl_err_q;
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_ifetch_pq.sv
// Self-checking bench for ifetch_pq: vector table plus corner sequences.
// Memory model returns word index n for word address n.
module tb_ifetch_pq;

  logic        clk = 1'b0;
  logic        reset;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_en;
  logic [29:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
`ifdef IFETCH_ALIGN_CHK_EN
  logic        out_err;
`endif

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  ifetch_pq #(.XLEN(32), .DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk         (clk),
    .reset       (reset),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_en     (imem_en),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_pc      (out_pc),
    .out_instr   (out_instr)
`ifdef IFETCH_ALIGN_CHK_EN
    ,
    .out_err     (out_err)
`endif
  );

  always @(posedge clk) begin
    imem_rdata <= imem_en ? {2'b00, imem_addr} : 32'hDEAD_BEEF;
  end

  typedef struct {
    logic        rst;
    logic        rd;
    logic [31:0] rpc;
    logic        rdy;
    logic        en;
    logic        v;
    logic [31:0] pc;
    logic [31:0] ins;
  } vec_t;

  vec_t tbl [11];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic rs, input logic rd,
                      input logic [31:0] rpc, input logic rdy);
    @(negedge clk);
    reset       = rs;
    redirect    = rd;
    redirect_pc = rpc;
    out_ready   = rdy;
    #1;
  endtask

  int en_cnt;

  initial begin
    reset = 1'b1;
    redirect = 1'b0;
    redirect_pc = '0;
    out_ready = 1'b0;

    tbl[0]  = '{1'b1, 1'b0, 32'h0,   1'b1, 1'b0, 1'b0, 32'h0,   32'h0};
    tbl[1]  = '{1'b1, 1'b0, 32'h0,   1'b1, 1'b0, 1'b0, 32'h0,   32'h0};
    tbl[2]  = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 1'b0, 32'h0,   32'h0};
    tbl[3]  = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 1'b0, 32'h0,   32'h0};
    tbl[4]  = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 1'b1, 32'h0,   32'h0};
    tbl[5]  = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 1'b1, 32'h4,   32'h1};
    tbl[6]  = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 1'b1, 32'h8,   32'h2};
    tbl[7]  = '{1'b0, 1'b1, 32'h100, 1'b1, 1'b1, 1'b1, 32'hC,   32'h3};
    tbl[8]  = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 1'b0, 32'h0,   32'h0};
    tbl[9]  = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 1'b1, 32'h100, 32'h40};
    tbl[10] = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 1'b1, 32'h104, 32'h41};

    for (int i = 0; i < 11; i++) begin
      step(tbl[i].rst, tbl[i].rd, tbl[i].rpc, tbl[i].rdy);
      chk($sformatf("vec%0d_en", i), 32'(imem_en), 32'(tbl[i].en));
      chk($sformatf("vec%0d_valid", i), 32'(out_valid), 32'(tbl[i].v));
      chk($sformatf("vec%0d_pc", i), out_pc, tbl[i].pc);
      chk($sformatf("vec%0d_instr", i), out_instr, tbl[i].ins);
    end

    // Stall with out_ready low: exactly DEPTH fetches, then gap-free drain.
    step(1'b1, 1'b0, 32'h0, 1'b0);
    step(1'b1, 1'b0, 32'h0, 1'b0);
    en_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b0, 32'h0, 1'b0);
      en_cnt += int'(imem_en);
    end
    chk("stall_pulses", 32'(en_cnt), 32'd4);
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b0, 32'h0, 1'b1);
      chk($sformatf("drain%0d_valid", i), 32'(out_valid), 32'd1);
      chk($sformatf("drain%0d_pc", i), out_pc, 32'(i * 4));
      chk($sformatf("drain%0d_instr", i), out_instr, 32'(i));
    end

    // Redirect with 3 entries queued and one fetch in flight.
    step(1'b1, 1'b0, 32'h0, 1'b0);
    step(1'b1, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b1, 32'h100, 1'b1);
    chk("redir_en", 32'(imem_en), 32'd1);
    chk("redir_addr", 32'(imem_addr), 32'h40);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    chk("redir_p1_valid", 32'(out_valid), 32'd0);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    chk("redir_p2_pc", out_pc, 32'h100);
    chk("redir_p2_instr", out_instr, 32'h40);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    chk("redir_p3_pc", out_pc, 32'h104);

    // Back-to-back redirects: only the second target appears.
    step(1'b0, 1'b1, 32'h40, 1'b1);
    step(1'b0, 1'b1, 32'h80, 1'b1);
    chk("b2b_r2_valid", 32'(out_valid), 32'd0);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    chk("b2b_p1_valid", 32'(out_valid), 32'd0);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    chk("b2b_p2_pc", out_pc, 32'h80);
    chk("b2b_p2_instr", out_instr, 32'h20);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    chk("b2b_p3_pc", out_pc, 32'h84);

    // One-cycle reset with a full queue.
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 32'h0, 1'b0);
    chk("full_valid", 32'(out_valid), 32'd1);
    step(1'b1, 1'b1, 32'h300, 1'b0);
    chk("rst_en", 32'(imem_en), 32'd0);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    chk("rst_p1_valid", 32'(out_valid), 32'd0);
    chk("rst_p1_en", 32'(imem_en), 32'd1);
    chk("rst_p1_addr", 32'(imem_addr), 32'h0);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    chk("rst_p2_valid", 32'(out_valid), 32'd0);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    chk("rst_p3_pc", out_pc, 32'h0);
    chk("rst_p3_valid", 32'(out_valid), 32'd1);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    chk("rst_p4_pc", out_pc, 32'h4);

`ifdef IFETCH_ALIGN_CHK_EN
    step(1'b0, 1'b1, 32'h102, 1'b0);
    chk("mis_en", 32'(imem_en), 32'd0);
    step(1'b0, 1'b0, 32'h0, 1'b0);
    chk("mis_p1_valid", 32'(out_valid), 32'd0);
    chk("mis_p1_en", 32'(imem_en), 32'd0);
    step(1'b0, 1'b0, 32'h0, 1'b0);
    chk("mis_p2_pc", out_pc, 32'h102);
    chk("mis_p2_err", 32'(out_err), 32'd1);
    chk("mis_p2_instr", out_instr, 32'h0);
    en_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, 32'h0, 1'b0);
      en_cnt += int'(imem_en);
    end
    chk("mis_halt_pulses", 32'(en_cnt), 32'd0);
    step(1'b0, 1'b1, 32'h200, 1'b1);
    chk("mis_r2_en", 32'(imem_en), 32'd1);
    chk("mis_r2_addr", 32'(imem_addr), 32'h80);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    chk("mis_r2_pc", out_pc, 32'h200);
    chk("mis_r2_err", 32'(out_err), 32'd0);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    chk("mis_r2_next", out_pc, 32'h204);
`else
    step(1'b0, 1'b1, 32'h102, 1'b1);
    chk("lo_en", 32'(imem_en), 32'd1);
    chk("lo_addr", 32'(imem_addr), 32'h40);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    chk("lo_pc", out_pc, 32'h100);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    chk("lo_next", out_pc, 32'h104);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
